// File: rtl/spi_target_pkg.sv
// Shared types, register map and command-byte layout for the SPI target.
package spi_target_pkg;

  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned TEMP_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_TEMP_HI = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_TEMP_LO = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CFG0    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CFG1    = 2'd3;

  localparam int unsigned CMD_RW_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 1;
  localparam int unsigned CMD_ADDR_LSB = 0;

  // Register-map read mux.
  function automatic logic [BYTE_W-1:0] reg_read(
    input logic [ADDR_W-1:0] addr,
    input logic [TEMP_W-1:0] snap,
    input logic [BYTE_W-1:0] c0,
    input logic [BYTE_W-1:0] c1
  );
    logic [BYTE_W-1:0] val;
    val = '0;
    case (addr)
      ADDR_TEMP_HI: val = snap[TEMP_W-1:BYTE_W];
      ADDR_TEMP_LO: val = snap[BYTE_W-1:0];
      ADDR_CFG0:    val = c0;
      ADDR_CFG1:    val = c1;
      default:      val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Synchronises sck/cs/mosi into clk_in and derives sck and cs edges.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic sck_rise_c,
  output logic sck_fall_c,
  output logic cs_fall_c,
  output logic cs_rise_c,
  output logic cs_level_c,
  output logic mosi_level_c
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev;
  logic                   cs_prev;

  // Shift chains plus one extra sample of sck/cs for edge detection.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sck_q    <= '1;
      cs_q     <= '1;
      mosi_q   <= '0;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q     <= {cs_q[SYNC_STAGES-2:0], cs};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_prev <= sck_q[SYNC_STAGES-1];
      cs_prev  <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise_c   =  sck_q[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall_c   = ~sck_q[SYNC_STAGES-1] &  sck_prev;
  assign cs_fall_c    = ~cs_q[SYNC_STAGES-1]  &  cs_prev;
  assign cs_rise_c    =  cs_q[SYNC_STAGES-1]  & ~cs_prev;
  assign cs_level_c   =  cs_q[SYNC_STAGES-1];
  assign mosi_level_c =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target.sv
// Mode-3 SPI target exposing a temperature snapshot and two config registers.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] CFG0_RESET  = 8'h00,
  parameter logic [BYTE_W-1:0] CFG1_RESET  = 8'h00
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [TEMP_W-1:0] temp_in,
  output logic [BYTE_W-1:0] cfg0,
  output logic [BYTE_W-1:0] cfg1,
  output logic              wr_strobe,
  output logic              abort
);

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;
  logic cs_level;
  logic mosi_level;

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BYTE_W-1:0]      shift_in;
  logic [BYTE_W-1:0]      shift_out;
  logic [ADDR_W-1:0]      addr;
  logic [TEMP_W-1:0]      temp_snap;

  logic [BYTE_W-1:0]      rx_byte;
  logic [ADDR_W-1:0]      cmd_addr;
  logic                   byte_done;
  logic                   partial;

  spi_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sck          (sck),
    .cs           (cs),
    .mosi         (mosi),
    .sck_rise_c   (sck_rise),
    .sck_fall_c   (sck_fall),
    .cs_fall_c    (cs_fall),
    .cs_rise_c    (cs_rise),
    .cs_level_c   (cs_level),
    .mosi_level_c (mosi_level)
  );

  assign rx_byte   = {shift_in[BYTE_W-2:0], mosi_level};
  assign cmd_addr  = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign byte_done = sck_rise && (bit_cnt == BIT_CNT_W'(7));
  // A cs rise with bits pending (including one arriving this cycle) loses a byte.
  assign partial   = ((bit_cnt != '0) || sck_rise) && !byte_done;

  // Transaction FSM with shifters, register file and strobes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      temp_snap <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      cfg0      <= CFG0_RESET;
      cfg1      <= CFG1_RESET;
      wr_strobe <= 1'b0;
      abort     <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      abort     <= 1'b0;
      miso_oe   <= ~cs_level;

      if (cs_fall) begin
        state     <= CMD;
        bit_cnt   <= '0;
        shift_in  <= '0;
        shift_out <= '0;
        temp_snap <= temp_in;
        miso      <= 1'b0;
      end else if (state != IDLE) begin
        if (sck_rise) begin
          shift_in <= rx_byte;
          bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        end

        if (sck_fall) begin
          if (state == RD) begin
            miso      <= shift_out[BYTE_W-1];
            shift_out <= {shift_out[BYTE_W-2:0], 1'b0};
          end else begin
            miso <= 1'b0;
          end
        end

        if (byte_done) begin
          case (state)
            CMD: begin
              if (rx_byte[CMD_RW_BIT]) begin
                state     <= RD;
                shift_out <= reg_read(cmd_addr, temp_snap, cfg0, cfg1);
                addr      <= cmd_addr + ADDR_W'(1);
              end else begin
                state <= WR;
                addr  <= cmd_addr;
              end
            end
            RD: begin
              shift_out <= reg_read(addr, temp_snap, cfg0, cfg1);
              addr      <= addr + ADDR_W'(1);
            end
            WR: begin
              // Temperature bytes are read-only; writes to them vanish.
              if (addr == ADDR_CFG0) begin
                cfg0      <= rx_byte;
                wr_strobe <= 1'b1;
              end else if (addr == ADDR_CFG1) begin
                cfg1      <= rx_byte;
                wr_strobe <= 1'b1;
              end
              addr <= addr + ADDR_W'(1);
            end
            default: ;
          endcase
        end

        // End of transaction wins over any state change above.
        if (cs_rise) begin
          state   <= IDLE;
          bit_cnt <= '0;
          miso    <= 1'b0;
          if (partial) abort <= 1'b1;
        end
      end else begin
        miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Randomised and directed bench for spi_target against a transaction-level model.
module tb_spi_target;

  localparam int unsigned HALF      = 8;
  localparam logic [7:0]  C0R       = 8'h5A;
  localparam logic [7:0]  C1R       = 8'hC3;

  logic        clk_in;
  logic        rst_in;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] temp_in;
  logic [7:0]  cfg0;
  logic [7:0]  cfg1;
  logic        wr_strobe;
  logic        abort;

  spi_target #(
    .SYNC_STAGES (3),
    .CFG0_RESET  (C0R),
    .CFG1_RESET  (C1R)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sck       (sck),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .temp_in   (temp_in),
    .cfg0      (cfg0),
    .cfg1      (cfg1),
    .wr_strobe (wr_strobe),
    .abort     (abort)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Model state and compare requests (written only by the stimulus process).
  logic [7:0] m_cfg0, m_cfg1;
  int         exp_strobe_tot, exp_abort_tot;
  logic       miso_win, exp_miso;
  logic       oe_win, exp_oe;
  logic       cfg_win, lit_win, cnt_win;
  logic [7:0] lit0, lit1;
  logic [7:0] tx [4];
  logic [7:0] lit_rd [4];

  // Written only by the compare process.
  int checks, failures;
  int strobe_cnt, abort_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare process: every clk_in cycle, check whatever the stimulus marked meaningful.
  always @(negedge clk_in) begin
    if (wr_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
    if (abort === 1'b1)     abort_cnt  = abort_cnt + 1;
    if (miso_win) chk("miso", 32'(miso), 32'(exp_miso));
    if (oe_win)   chk("miso_oe", 32'(miso_oe), 32'(exp_oe));
    if (cfg_win) begin
      chk("cfg0_model", 32'(cfg0), 32'(m_cfg0));
      chk("cfg1_model", 32'(cfg1), 32'(m_cfg1));
    end
    if (lit_win) begin
      chk("cfg0_literal", 32'(cfg0), 32'(lit0));
      chk("cfg1_literal", 32'(cfg1), 32'(lit1));
    end
    if (cnt_win) begin
      chk("wr_strobe_count", 32'(strobe_cnt), 32'(exp_strobe_tot));
      chk("abort_count", 32'(abort_cnt), 32'(exp_abort_tot));
    end
  end

  // Register contents as seen by a reader holding the given temperature snapshot.
  function automatic logic [7:0] model_reg(input logic [1:0] a, input logic [15:0] snap);
    logic [7:0] v;
    case (a)
      2'd0:    v = snap[15:8];
      2'd1:    v = snap[7:0];
      2'd2:    v = m_cfg0;
      default: v = m_cfg1;
    endcase
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One SPI bit: fall + drive mosi, check miso late in the low phase, then rise.
  task automatic sck_bit(input logic mo, input logic chk_en, input logic ex, input logic last);
    sck  = 1'b0;
    mosi = mo;
    wait_clk(HALF - 3);
    exp_miso = ex;
    miso_win = chk_en;
    wait_clk(3);
    miso_win = 1'b0;
    if (last) begin
      oe_win = 1'b0;
      cs     = 1'b1;
    end
    sck = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic lit_cfg(input logic [7:0] a, input logic [7:0] b);
    lit0    = a;
    lit1    = b;
    lit_win = 1'b1;
    wait_clk(1);
    lit_win = 1'b0;
  endtask

  // Full transaction: command, nbytes data bytes, optional partial tail.
  task automatic txn(input logic [7:0] cmd, input int nbytes, input int part_bits,
                     input logic sim_end, input logic use_lit,
                     input logic chg, input logic [15:0] temp_mid);
    logic [1:0]  a;
    logic [7:0]  rb;
    logic [15:0] snap;
    logic        last;
    logic        se;
    se   = sim_end && (part_bits == 0);
    snap = temp_in;
    cs   = 1'b0;
    wait_clk(2 * HALF);
    exp_oe = 1'b1;
    oe_win = 1'b1;
    if (!chg) temp_in = 16'($urandom);
    for (int i = 7; i >= 0; i--)
      sck_bit(cmd[i], 1'b1, 1'b0, se && (nbytes == 0) && (i == 0));
    a = cmd[1:0];
    for (int b = 0; b < nbytes; b++) begin
      if (cmd[7]) rb = use_lit ? lit_rd[b] : model_reg(a, snap);
      else        rb = tx[b];
      for (int i = 7; i >= 0; i--) begin
        last = se && (b == nbytes - 1) && (i == 0);
        if (cmd[7]) sck_bit(1'($urandom), 1'b1, rb[i], last);
        else        sck_bit(rb[i], 1'b0, 1'b0, last);
      end
      if (!cmd[7]) begin
        if (a == 2'd2) begin
          m_cfg0 = rb;
          exp_strobe_tot = exp_strobe_tot + 1;
        end else if (a == 2'd3) begin
          m_cfg1 = rb;
          exp_strobe_tot = exp_strobe_tot + 1;
        end
      end
      a = a + 2'd1;
      if (chg && b == 0) temp_in = temp_mid;
    end
    for (int i = 0; i < part_bits; i++) sck_bit(1'($urandom), 1'b0, 1'b0, 1'b0);
    if (part_bits > 0) exp_abort_tot = exp_abort_tot + 1;
    if (!se) begin
      oe_win = 1'b0;
      wait_clk(HALF);
      cs = 1'b1;
    end
    wait_clk(4 * HALF);
    exp_oe  = 1'b0;
    oe_win  = 1'b1;
    cfg_win = 1'b1;
    cnt_win = 1'b1;
    wait_clk(1);
    oe_win  = 1'b0;
    cfg_win = 1'b0;
    cnt_win = 1'b0;
  endtask

  initial begin
    logic [7:0] cmd;
    int         nb, pb;
    logic       se;
    logic [7:0] rd_hi;

    checks = 0; failures = 0; strobe_cnt = 0; abort_cnt = 0;
    rst_in = 1'b1; cs = 1'b1; sck = 1'b1; mosi = 1'b0; temp_in = 16'h0000;
    miso_win = 1'b0; exp_miso = 1'b0; oe_win = 1'b0; exp_oe = 1'b0;
    cfg_win = 1'b0; lit_win = 1'b0; cnt_win = 1'b0; lit0 = '0; lit1 = '0;
    m_cfg0 = C0R; m_cfg1 = C1R; exp_strobe_tot = 0; exp_abort_tot = 0;
    for (int k = 0; k < 4; k++) begin tx[k] = '0; lit_rd[k] = '0; end

    // Reset state.
    wait_clk(3);
    exp_miso = 1'b0; miso_win = 1'b1; exp_oe = 1'b0; oe_win = 1'b1; cnt_win = 1'b1;
    lit_cfg(C0R, C1R);
    miso_win = 1'b0; oe_win = 1'b0; cnt_win = 1'b0;
    rst_in = 1'b0;
    wait_clk(4);

    // Read temperature from addr0.
    temp_in = 16'h1A2B; lit_rd[0] = 8'h1A; lit_rd[1] = 8'h2B;
    txn(8'h80, 2, 0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Write both config registers.
    tx[0] = 8'h55; tx[1] = 8'hAA;
    txn(8'h02, 2, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    lit_cfg(8'h55, 8'hAA);

    // Address wrap from addr3.
    temp_in = 16'h1A2B; lit_rd[0] = 8'hAA; lit_rd[1] = 8'h1A; lit_rd[2] = 8'h2B;
    txn(8'h83, 3, 0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Abort after 5 data bits.
    txn(8'h02, 0, 5, 1'b0, 1'b0, 1'b0, 16'h0);
    lit_cfg(8'h55, 8'hAA);

    // Snapshot coherency across a temperature change.
    temp_in = 16'h00FF; lit_rd[0] = 8'h00; lit_rd[1] = 8'hFF;
    txn(8'h80, 2, 0, 1'b0, 1'b1, 1'b1, 16'h0100);

    // Write to a read-only address.
    tx[0] = 8'h77;
    txn(8'h00, 1, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    lit_cfg(8'h55, 8'hAA);

    // cs rise coincident with the 8th sck rise completes the byte.
    tx[0] = 8'h3C;
    txn(8'h03, 1, 0, 1'b1, 1'b0, 1'b0, 16'h0);
    lit_cfg(8'h55, 8'h3C);

    // Reset in the middle of a read.
    temp_in = 16'hE42B; rd_hi = 8'hE4; cmd = 8'h80;
    cs = 1'b0;
    wait_clk(2 * HALF);
    for (int i = 7; i >= 0; i--) sck_bit(cmd[i], 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 5; i--) sck_bit(1'b0, 1'b1, rd_hi[i], 1'b0);
    sck = 1'b0;
    wait_clk(2);
    rst_in = 1'b1;
    wait_clk(2);
    m_cfg0 = C0R; m_cfg1 = C1R;
    exp_oe = 1'b0; oe_win = 1'b1; exp_miso = 1'b0; miso_win = 1'b1;
    lit_cfg(C0R, C1R);
    oe_win = 1'b0; miso_win = 1'b0;
    cs = 1'b1; sck = 1'b1;
    wait_clk(2);
    rst_in = 1'b0;
    wait_clk(4 * HALF);
    lit_rd[0] = C0R; lit_rd[1] = C1R;
    txn(8'h82, 2, 0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Randomised transactions against the model.
    for (int n = 0; n < 30; n++) begin
      cmd = 8'($urandom);
      nb  = int'($urandom_range(0, 4));
      pb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      se  = (pb == 0) ? 1'($urandom) : 1'b0;
      for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
      temp_in = 16'($urandom);
      txn(cmd, nb, pb, se, 1'b0, 1'b0, 16'h0);
    end

    wait_clk(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages in each sck/cs/mosi synchronizer (legal range 2..4).
REQ-002 Parameter CFG0_RESET, default 8'h00, reset value of configuration register 2.
REQ-003 Parameter CFG1_RESET, default 8'h00, reset value of configuration register 3.
REQ-004 clk_in  input  1  system clock, at least 8x the sck frequency.
REQ-005 rst_in  input  1  reset; asynchronous, active-high.
REQ-006 sck  input  1  SPI clock from the controller; idles high (mode 3).
REQ-007 cs  input  1  chip select, active-low.
REQ-008 mosi  input  1  controller-to-target data, MSB first.
REQ-009 miso  output  1  target-to-controller data.
REQ-010 miso_oe  output  1  high while cs is synchronised low; miso is tri-stated externally when low.
REQ-011 temp_in  input  16  live temperature sample from the sensor core.
REQ-012 cfg0, cfg1  output  8 each  current contents of configuration registers 2 and 3.
REQ-013 wr_strobe  output  1  one-clk_in pulse when a configuration register is written.
REQ-014 abort  output  1  one-clk_in pulse when cs deasserts mid-byte.

Function
REQ-015 sck, cs and mosi SHALL each pass through a SYNC_STAGES synchroniser; sck edges SHALL be detected on clk_in by comparing the last two synchronised samples.
REQ-016 mosi SHALL be sampled on each synchronised sck rising edge and shifted in MSB first; a byte completes on the 8th rising edge after cs falls or after the previous byte.
REQ-017 miso SHALL update on each synchronised sck falling edge, and also on the clk_in cycle after the cs falling edge is detected; it SHALL be valid within SYNC_STAGES+2 clk_in cycles of the sck edge.
REQ-018 The byte position distinguishes command from data; the first byte after cs falls is the command byte, and dc is not an input of this block.
REQ-019 Command byte: bit7=1 read, bit7=0 write; bits1:0 start address; bits6:2 ignored.
REQ-020 Register map: addr0=temp_snap[15:8] (RO), addr1=temp_snap[7:0] (RO), addr2=cfg0 (RW), addr3=cfg1 (RW).
REQ-021 temp_snap SHALL capture temp_in on the clk_in cycle in which the cs falling edge is detected, and hold it for the whole transaction so that byte reads are coherent.
REQ-022 The FSM SHALL have the states IDLE, CMD, RD and WR.
REQ-023 IDLE->CMD on the cs falling edge; CMD->RD or CMD->WR on command byte completion according to bit7; any state->IDLE on the cs rising edge.
REQ-024 RD: the byte at the current address SHALL be loaded into the output shifter at command completion and after each subsequent byte; the address then increments mod 4 (3 wraps to 0).
REQ-025 WR: each completed data byte SHALL be written to the current address; the address then increments mod 4.
REQ-026 A write to addr 0 or 1 SHALL be discarded silently, with no wr_strobe.
REQ-027 During CMD, and when no transaction is active, miso SHALL be 0.
REQ-028 cs rising with a partial byte (bit count 1..7) SHALL discard that byte, leave registers unchanged, and pulse abort once.
REQ-029 A cs rise on the same clk_in cycle as an 8th sck rising edge SHALL complete the byte first and then return to IDLE, with no abort pulse.
REQ-030 sck edges while cs is high SHALL be ignored.

Reset
REQ-031 While rst_in is high: state=IDLE, miso=0, miso_oe=0, cfg0=CFG0_RESET, cfg1=CFG1_RESET, wr_strobe=0, abort=0, temp_snap=0, bit counter=0, synchronisers set to sck=1, cs=1, mosi=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction; after reset releases, the block SHALL wait for a fresh cs falling edge.

Structure
REQ-033 Package spi_target_pkg SHALL hold the state enum, the register address constants (ADDR_TEMP_HI, ADDR_TEMP_LO, ADDR_CFG0, ADDR_CFG1) and the command bit positions.
REQ-034 The three-input synchroniser and edge detector SHALL be one sub-module, spi_sync, instantiated once.

Verification
REQ-035 Read: cmd 8'h80, temp_in=16'h1A2B, 2 read bytes -> miso returns 8'h1A then 8'h2B.
REQ-036 Write: cmd 8'h02, data 8'h55, 8'hAA -> cfg0=8'h55, cfg1=8'hAA, two wr_strobe pulses.
REQ-037 Wrap: cmd 8'h83, 3 read bytes with cfg1=8'hAA and temp_in=16'h1A2B -> 8'hAA, 8'h1A, 8'h2B.
REQ-038 Abort: write cmd 8'h02, then cs raised after 5 data bits -> one abort pulse, cfg0 unchanged.
REQ-039 Coherency: temp_in changes from 16'h00FF to 16'h0100 between byte 0 and byte 1 of a read from addr0 -> 8'h00, 8'hFF.
REQ-040 RO write / reset: cmd 8'h00 with data 8'h77 -> no wr_strobe; rst_in asserted mid-read -> miso_oe=0 and cfg0/cfg1 return to their reset values.
